dimm_cmd_decoder: RTL and testbench
===================================

# dimm_cmd_decoder

Registered DDR4 command/address decoder and per-bank state tracker for the DIMM emulation model. It sits between the controller-facing CA pins and the per-chip bank FSMs. It samples `cs_n`, `act_n`, `A`, `bg` and `ba` on every `ck_t` rising edge and decodes the full DDR4 command truth table per rank. It tracks the open/closed row of every bank and checks tRCD/tRP/tRAS. Each sampled command produces either one decoded command pulse or one error pulse.

## Interface
Parameters:
- ADDRWIDTH, 17, row address width; A16/A15/A14 double as RAS_n/CAS_n/WE_n.
- RANKS, 2, number of ranks; one cs_n bit each.
- BANKGROUPS, 4, bank groups per rank.
- BANKSPERGROUP, 4, banks per group.
- COLS, 1024, columns; CADDRWIDTH = $clog2(COLS).
- TRCD, 4, minimum cycles from ACT to RD/WR on the same bank.
- TRP, 4, minimum cycles from PRE (or auto-precharge) to ACT on the same bank.
- TRAS, 10, minimum cycles from ACT to PRE on the same bank.

Ports:
- ck_t  in  1  clock; all inputs sampled on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- cke  in  1  clock enable; when low, commands are ignored.
- cs_n  in  RANKS  chip select per rank, active-low.
- act_n  in  1  activate command input.
- A  in  ADDRWIDTH  row address, or command bits plus column address.
- bg  in  $clog2(BANKGROUPS)  bank group.
- ba  in  $clog2(BANKSPERGROUP)  bank address.
- parity  in  1  CA parity bit; used only with DIMM_CA_PARITY_EN.
- cmd_valid  out  1  one-cycle pulse: a legal command was decoded.
- cmd_code  out  4  0 NOP, 1 ACT, 2 RD, 3 RDA, 4 WR, 5 WRA, 6 PRE, 7 PREA, 8 REF, 9 MRS, 10 ZQC.
- cmd_rank  out  $clog2(RANKS)  target rank.
- cmd_bg, cmd_ba  out  bg/ba widths  target bank.
- cmd_row  out  ADDRWIDTH  A as captured on ACT.
- cmd_col  out  CADDRWIDTH  A[CADDRWIDTH-1:0] as captured on RD/WR.
- bank_open  out  RANKS*BANKGROUPS*BANKSPERGROUP  1 = row open. Bit index = (rank*BANKGROUPS+bg)*BANKSPERGROUP+ba.
- err_valid  out  1  one-cycle pulse: the command was rejected.
- err_code  out  3  1 parity, 2 multi-rank select, 3 bank already open, 4 bank closed, 5 tRCD, 6 tRAS, 7 tRP/REF with open bank.
- alert_n  out  1  low for one cycle on a parity error; otherwise high.

## Operation
- Decode applies only when cke=1 and exactly one cs_n bit is low.
  - All cs_n high, or cke=0: DES; no pulse of any kind.
  - Two or more cs_n bits low: err 2.
- act_n=0: ACT.
- act_n=1: {A16,A15,A14} decodes as follows.
  - LLL: MRS.
  - LLH: REF.
  - LHL: PRE, or PREA if A10=1.
  - LHH: NOP.
  - HLH: RD, or RDA if A10=1.
  - HLL: WR, or WRA if A10=1.
  - HHL: ZQC.
  - HHH: NOP.
- Each bank holds an open flag, an open row, and a saturating since-ACT/since-PRE counter. Counter width is $clog2(max(TRAS,TRP,TRCD)+1).
- ACT:
  - Bank open: err 3.
  - Since-PRE count < TRP: err 7.
  - Otherwise: set open, store row, clear the counter.
- RD/WR/RDA/WRA:
  - Bank closed: err 4.
  - Since-ACT count < TRCD: err 5.
  - RDA/WRA: on success, close the bank and restart the since-PRE count in the same cycle.
- PRE:
  - Bank open and count < TRAS: err 6.
  - Bank open, otherwise: close the bank and clear the counter.
  - Bank already closed: legal; cmd_valid pulses with no state change.
- PREA: the tRAS check applies to every open bank in the rank. Any violation produces err 6 and closes no banks.
- REF with any bank of that rank open: err 7.
- MRS, ZQC and NOP are always legal.
- Rejected commands never change bank state and never assert cmd_valid.
- Error priority: parity > multi-rank > state/timing.
- Counters run every cycle regardless of cke and saturate at their maximum.

## Timing
- Latency is 1 cycle: a command sampled at edge N drives cmd_* or err_* from edge N+1 for one cycle.
- Boundary rule: ACT at edge N makes RD legal at edge N+TRCD and illegal at N+TRCD-1. TRP and TRAS follow the same rule.
- Back-to-back commands on consecutive edges are each decoded independently. A command at N+1 sees the state updated by the command at N.
- Reset values:
  - cmd_valid=0, err_valid=0, alert_n=1, all data outputs 0.
  - bank_open all 0.
  - All counters saturated, so ACT is legal immediately after reset.
- Reset asserted mid-sequence clears all state at the next edge. Commands sampled while reset_n=0 are discarded.

## Configuration
- DIMM_CA_PARITY_EN defined: even parity is checked over {act_n, A, bg, ba, parity}.
  - A mismatch gives err 1, alert_n=0 for one cycle, and the command is dropped.
- DIMM_CA_PARITY_EN undefined: the parity input is ignored, err 1 is never produced, and alert_n is tied to 1.

## Test plan
- Reset, then ACT r0/bg1/ba2 row 0x1234 → cmd_code=1 next cycle, bank_open bit 6 set, cmd_row=0x1234.
- ACT, then RD at +3 and at +4 (TRCD=4) → first gives err_code=5, second gives cmd_code=2 with cmd_col=A[9:0].
- ACT, then PRE at +9 → err 6; PRE at +10 → cmd_code=6 and bit cleared; ACT at +13 → err 7; ACT at +14 → accepted.
- RDA on an open bank → cmd_code=3 and bank closes. REF with one bank open → err 7. cs_n=2'b00 → err 2.
- With DIMM_CA_PARITY_EN defined: flip the parity bit on an ACT → err 1, alert_n low for 1 cycle, bank_open unchanged.
- Assert reset_n=0 for one edge with 3 banks open → bank_open=0 and no pulses on the following edge.

Source files
------------

// File: rtl/dimm_cmd_decoder.sv
// Registered DDR4 CA decoder with per-bank open-row and tRCD/tRP/tRAS tracking.
// CA parity checking is compiled in only when DIMM_CA_PARITY_EN is defined.
module dimm_cmd_decoder #(
    parameter int unsigned ADDRWIDTH     = 17,
    parameter int unsigned RANKS         = 2,
    parameter int unsigned BANKGROUPS    = 4,
    parameter int unsigned BANKSPERGROUP = 4,
    parameter int unsigned COLS          = 1024,
    parameter int unsigned TRCD          = 4,
    parameter int unsigned TRP           = 4,
    parameter int unsigned TRAS          = 10,
    localparam int unsigned RankW        = (RANKS > 1) ? $clog2(RANKS) : 1,
    localparam int unsigned BgW          = (BANKGROUPS > 1) ? $clog2(BANKGROUPS) : 1,
    localparam int unsigned BaW          = (BANKSPERGROUP > 1) ? $clog2(BANKSPERGROUP) : 1,
    localparam int unsigned CADDRWIDTH   = $clog2(COLS),
    localparam int unsigned NumBanks     = RANKS * BANKGROUPS * BANKSPERGROUP
) (
    input  logic                  ck_t,
    input  logic                  reset_n,
    input  logic                  cke,
    input  logic [RANKS-1:0]      cs_n,
    input  logic                  act_n,
    input  logic [ADDRWIDTH-1:0]  A,
    input  logic [BgW-1:0]        bg,
    input  logic [BaW-1:0]        ba,
    input  logic                  parity,
    output logic                  cmd_valid,
    output logic [3:0]            cmd_code,
    output logic [RankW-1:0]      cmd_rank,
    output logic [BgW-1:0]        cmd_bg,
    output logic [BaW-1:0]        cmd_ba,
    output logic [ADDRWIDTH-1:0]  cmd_row,
    output logic [CADDRWIDTH-1:0] cmd_col,
    output logic [NumBanks-1:0]   bank_open,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic                  alert_n
);

    localparam int unsigned BankPerRank = BANKGROUPS * BANKSPERGROUP;
    localparam int unsigned TMax01      = (TRAS > TRP) ? TRAS : TRP;
    localparam int unsigned TMax        = (TMax01 > TRCD) ? TMax01 : TRCD;
    localparam int unsigned CntW        = $clog2(TMax + 1);

    typedef enum logic [3:0] {
        CmdNop  = 4'd0,
        CmdAct  = 4'd1,
        CmdRd   = 4'd2,
        CmdRda  = 4'd3,
        CmdWr   = 4'd4,
        CmdWra  = 4'd5,
        CmdPre  = 4'd6,
        CmdPrea = 4'd7,
        CmdRef  = 4'd8,
        CmdMrs  = 4'd9,
        CmdZqc  = 4'd10
    } cmd_e;

    typedef enum logic [2:0] {
        ErrNone      = 3'd0,
        ErrParity    = 3'd1,
        ErrMultiRank = 3'd2,
        ErrOpen      = 3'd3,
        ErrClosed    = 3'd4,
        ErrTrcd      = 3'd5,
        ErrTras      = 3'd6,
        ErrTrp       = 3'd7
    } err_e;

    // The counter is cleared on the accepting edge, so at edge N+k it reads k-1.
    function automatic logic too_soon(input logic [CntW-1:0] cnt, input int unsigned lim);
        return (32'(cnt) + 32'd1) < lim;
    endfunction

    logic [RANKS-1:0][BankPerRank-1:0]                open_q, open_d;
    logic [RANKS-1:0][BankPerRank-1:0][ADDRWIDTH-1:0] row_q, row_d;
    logic [RANKS-1:0][BankPerRank-1:0][CntW-1:0]      cnt_q, cnt_d;

    logic                  cmd_valid_q, cmd_valid_d;
    cmd_e                  cmd_code_q, cmd_code_d;
    logic [RankW-1:0]      cmd_rank_q, cmd_rank_d;
    logic [BgW-1:0]        cmd_bg_q, cmd_bg_d;
    logic [BaW-1:0]        cmd_ba_q, cmd_ba_d;
    logic [ADDRWIDTH-1:0]  cmd_row_q, cmd_row_d;
    logic [CADDRWIDTH-1:0] cmd_col_q, cmd_col_d;
    logic                  err_valid_q, err_valid_d;
    err_e                  err_code_q, err_code_d;
    logic                  alert_n_q, alert_n_d;

    logic [RANKS-1:0]           cs_low;
    logic                       sel_any;
    logic                       sel_multi;
    logic [RankW-1:0]           rank_sel;
    logic [BgW+BaW-1:0]         bank_sel;
    logic                       par_err;
    cmd_e                       dec_cmd;
    err_e                       err;
    logic                       prea_viol;

    assign cs_low    = ~cs_n;
    assign sel_any   = cke && (|cs_low);
    assign sel_multi = (cs_low & (cs_low - 1'b1)) != '0;
    assign bank_sel  = {bg, ba};

`ifdef DIMM_CA_PARITY_EN
    assign par_err = ^{act_n, A, bg, ba, parity};
`else
    logic unused_parity;
    assign unused_parity = parity;
    assign par_err       = 1'b0;
`endif

    always_comb begin
        rank_sel = '0;
        for (int unsigned r = 0; r < RANKS; r++) begin
            if (cs_low[r]) begin
                rank_sel = RankW'(r);
            end
        end
    end

    // A16/A15/A14 act as RAS_n/CAS_n/WE_n when act_n is high.
    always_comb begin
        dec_cmd = CmdNop;
        if (!act_n) begin
            dec_cmd = CmdAct;
        end else begin
            case (A[16:14])
                3'b000:  dec_cmd = CmdMrs;
                3'b001:  dec_cmd = CmdRef;
                3'b010:  dec_cmd = A[10] ? CmdPrea : CmdPre;
                3'b101:  dec_cmd = A[10] ? CmdRda : CmdRd;
                3'b100:  dec_cmd = A[10] ? CmdWra : CmdWr;
                3'b110:  dec_cmd = CmdZqc;
                default: dec_cmd = CmdNop;
            endcase
        end
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        for (int unsigned r = 0; r < RANKS; r++) begin
            for (int unsigned b = 0; b < BankPerRank; b++) begin
                cnt_d[r][b] = (cnt_q[r][b] == '1) ? cnt_q[r][b] : cnt_q[r][b] + 1'b1;
            end
        end
        cmd_valid_d = 1'b0;
        cmd_code_d  = CmdNop;
        cmd_rank_d  = cmd_rank_q;
        cmd_bg_d    = cmd_bg_q;
        cmd_ba_d    = cmd_ba_q;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;
        err_valid_d = 1'b0;
        err_code_d  = ErrNone;
        alert_n_d   = 1'b1;
        err         = ErrNone;
        prea_viol   = 1'b0;

        if (sel_any) begin
            if (par_err) begin
                err = ErrParity;
            end else if (sel_multi) begin
                err = ErrMultiRank;
            end else begin
                unique case (dec_cmd)
                    CmdAct: begin
                        if (open_q[rank_sel][bank_sel]) begin
                            err = ErrOpen;
                        end else if (too_soon(cnt_q[rank_sel][bank_sel], TRP)) begin
                            err = ErrTrp;
                        end else begin
                            open_d[rank_sel][bank_sel] = 1'b1;
                            row_d[rank_sel][bank_sel]  = A;
                            cnt_d[rank_sel][bank_sel]  = '0;
                        end
                    end
                    CmdRd, CmdRda, CmdWr, CmdWra: begin
                        if (!open_q[rank_sel][bank_sel]) begin
                            err = ErrClosed;
                        end else if (too_soon(cnt_q[rank_sel][bank_sel], TRCD)) begin
                            err = ErrTrcd;
                        end else if (dec_cmd == CmdRda || dec_cmd == CmdWra) begin
                            open_d[rank_sel][bank_sel] = 1'b0;
                            cnt_d[rank_sel][bank_sel]  = '0;
                        end
                    end
                    CmdPre: begin
                        if (open_q[rank_sel][bank_sel]) begin
                            if (too_soon(cnt_q[rank_sel][bank_sel], TRAS)) begin
                                err = ErrTras;
                            end else begin
                                open_d[rank_sel][bank_sel] = 1'b0;
                                cnt_d[rank_sel][bank_sel]  = '0;
                            end
                        end
                    end
                    CmdPrea: begin
                        // All-or-nothing: one young bank blocks the whole rank.
                        for (int unsigned b = 0; b < BankPerRank; b++) begin
                            if (open_q[rank_sel][b] && too_soon(cnt_q[rank_sel][b], TRAS)) begin
                                prea_viol = 1'b1;
                            end
                        end
                        if (prea_viol) begin
                            err = ErrTras;
                        end else begin
                            for (int unsigned b = 0; b < BankPerRank; b++) begin
                                if (open_q[rank_sel][b]) begin
                                    open_d[rank_sel][b] = 1'b0;
                                    cnt_d[rank_sel][b]  = '0;
                                end
                            end
                        end
                    end
                    CmdRef: begin
                        if (|open_q[rank_sel]) begin
                            err = ErrTrp;
                        end
                    end
                    default: ;
                endcase
            end

            if (err != ErrNone) begin
                err_valid_d = 1'b1;
                err_code_d  = err;
                alert_n_d   = (err != ErrParity);
            end else begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = dec_cmd;
                cmd_rank_d  = rank_sel;
                cmd_bg_d    = bg;
                cmd_ba_d    = ba;
                if (dec_cmd == CmdAct) begin
                    cmd_row_d = A;
                end
                if (dec_cmd == CmdRd || dec_cmd == CmdRda ||
                    dec_cmd == CmdWr || dec_cmd == CmdWra) begin
                    cmd_row_d = row_q[rank_sel][bank_sel];
                    cmd_col_d = A[CADDRWIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge ck_t) begin
        if (!reset_n) begin
            open_q      <= '0;
            row_q       <= '0;
            cnt_q       <= '1;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CmdNop;
            cmd_rank_q  <= '0;
            cmd_bg_q    <= '0;
            cmd_ba_q    <= '0;
            cmd_row_q   <= '0;
            cmd_col_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ErrNone;
            alert_n_q   <= 1'b1;
        end else begin
            open_q      <= open_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_rank_q  <= cmd_rank_d;
            cmd_bg_q    <= cmd_bg_d;
            cmd_ba_q    <= cmd_ba_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            alert_n_q   <= alert_n_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_rank  = cmd_rank_q;
    assign cmd_bg    = cmd_bg_q;
    assign cmd_ba    = cmd_ba_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign bank_open = open_q;
    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign alert_n   = alert_n_q;

endmodule

// File: tb/tb_dimm_cmd_decoder.sv
// Directed bench for dimm_cmd_decoder: decode, bank state, timing boundaries and reset.
module tb_dimm_cmd_decoder;

    localparam logic [16:0] OpMrs = 17'h00000;
    localparam logic [16:0] OpRef = 17'h04000;
    localparam logic [16:0] OpPre = 17'h08000;
    localparam logic [16:0] OpNop = 17'h0C000;
    localparam logic [16:0] OpWr  = 17'h10000;
    localparam logic [16:0] OpRd  = 17'h14000;
    localparam logic [16:0] OpZqc = 17'h18000;
    localparam logic [16:0] A10   = 17'h00400;

    logic        ck_t = 1'b0;
    logic        reset_n;
    logic        cke;
    logic [1:0]  cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic        parity;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [0:0]  cmd_rank;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;
    logic [31:0] bank_open;
    logic        err_valid;
    logic [2:0]  err_code;
    logic        alert_n;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    dimm_cmd_decoder dut (
        .ck_t      (ck_t),
        .reset_n   (reset_n),
        .cke       (cke),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .A         (A),
        .bg        (bg),
        .ba        (ba),
        .parity    (parity),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_rank  (cmd_rank),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .bank_open (bank_open),
        .err_valid (err_valid),
        .err_code  (err_code),
        .alert_n   (alert_n)
    );

    always #5 ck_t = ~ck_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one command for one rising edge, then returns 1 time unit after it.
    task automatic issue(input logic [1:0] cs, input logic actn, input logic [16:0] a,
                         input logic [1:0] g, input logic [1:0] k, input logic flip);
        cs_n   = cs;
        act_n  = actn;
        A      = a;
        bg     = g;
        ba     = k;
        parity = (^{actn, a, g, k}) ^ flip;
        @(posedge ck_t);
        #1;
    endtask

    task automatic des(input int n);
        repeat (n) issue(2'b11, 1'b1, 17'h0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic expect_cmd(input string tag, input logic [3:0] code);
        check({tag, "_cv"}, 32'(cmd_valid), 32'd1);
        check({tag, "_ev"}, 32'(err_valid), 32'd0);
        check({tag, "_code"}, 32'(cmd_code), 32'(code));
    endtask

    task automatic expect_err(input string tag, input logic [2:0] code);
        check({tag, "_cv"}, 32'(cmd_valid), 32'd0);
        check({tag, "_ev"}, 32'(err_valid), 32'd1);
        check({tag, "_ecode"}, 32'(err_code), 32'(code));
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_cv"}, 32'(cmd_valid), 32'd0);
        check({tag, "_ev"}, 32'(err_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        cke     = 1'b1;
        cs_n    = 2'b11;
        act_n   = 1'b1;
        A       = '0;
        bg      = '0;
        ba      = '0;
        parity  = 1'b0;
        des(2);
        reset_n = 1'b1;
        expect_none("rst");
        check("rst_alert", 32'(alert_n), 32'd1);
        check("rst_open", bank_open, 32'h0);
        check("rst_row", 32'(cmd_row), 32'h0);
        check("rst_code", 32'(cmd_code), 32'h0);

        // E0: ACT r0/bg1/ba2 -> bank bit 6
        issue(2'b10, 1'b0, 17'h01234, 2'd1, 2'd2, 1'b0);
        expect_cmd("act0", 4'd1);
        check("act0_rank", 32'(cmd_rank), 32'd0);
        check("act0_bg", 32'(cmd_bg), 32'd1);
        check("act0_ba", 32'(cmd_ba), 32'd2);
        check("act0_row", 32'(cmd_row), 32'h1234);
        check("act0_open", bank_open, 32'h40);
        check("act0_alert", 32'(alert_n), 32'd1);

        // tRCD boundary: RD at +3 rejected, +4 accepted
        des(2);
        issue(2'b10, 1'b1, OpRd | 17'h155, 2'd1, 2'd2, 1'b0);
        expect_err("rd_p3", 3'd5);
        issue(2'b10, 1'b1, OpRd | 17'h2AB, 2'd1, 2'd2, 1'b0);
        expect_cmd("rd_p4", 4'd2);
        check("rd_p4_col", 32'(cmd_col), 32'h2AB);
        check("rd_p4_row", 32'(cmd_row), 32'h1234);
        check("rd_p4_open", bank_open, 32'h40);

        // tRAS boundary: PRE at +9 rejected, +10 accepted
        des(4);
        issue(2'b10, 1'b1, OpPre, 2'd1, 2'd2, 1'b0);
        expect_err("pre_p9", 3'd6);
        check("pre_p9_open", bank_open, 32'h40);
        issue(2'b10, 1'b1, OpPre, 2'd1, 2'd2, 1'b0);
        expect_cmd("pre_p10", 4'd6);
        check("pre_p10_open", bank_open, 32'h0);

        // tRP boundary: ACT at PRE+3 rejected, PRE+4 accepted
        des(2);
        issue(2'b10, 1'b0, 17'h00ABC, 2'd1, 2'd2, 1'b0);
        expect_err("act_p13", 3'd7);
        check("act_p13_open", bank_open, 32'h0);
        issue(2'b10, 1'b0, 17'h00ABC, 2'd1, 2'd2, 1'b0);
        expect_cmd("act_p14", 4'd1);
        check("act_p14_open", bank_open, 32'h40);
        check("act_p14_row", 32'(cmd_row), 32'h0ABC);

        // RDA auto-precharges
        des(3);
        issue(2'b10, 1'b1, OpRd | A10 | 17'h005, 2'd1, 2'd2, 1'b0);
        expect_cmd("rda", 4'd3);
        check("rda_open", bank_open, 32'h0);

        // Rank 1 bank 0/0 -> bit 16; REF on rank 1 rejected, rank 0 accepted
        issue(2'b01, 1'b0, 17'h1FFFF, 2'd0, 2'd0, 1'b0);
        expect_cmd("act_r1", 4'd1);
        check("act_r1_rank", 32'(cmd_rank), 32'd1);
        check("act_r1_open", bank_open, 32'h10000);
        issue(2'b01, 1'b1, OpRef, 2'd0, 2'd0, 1'b0);
        expect_err("ref_r1", 3'd7);
        issue(2'b10, 1'b1, OpRef, 2'd0, 2'd0, 1'b0);
        expect_cmd("ref_r0", 4'd8);

        issue(2'b00, 1'b1, OpNop, 2'd0, 2'd0, 1'b0);
        expect_err("multi", 3'd2);
        check("multi_open", bank_open, 32'h10000);

        cke = 1'b0;
        issue(2'b10, 1'b0, 17'h00001, 2'd3, 2'd3, 1'b0);
        expect_none("cke0");
        check("cke0_open", bank_open, 32'h10000);
        cke = 1'b1;

        issue(2'b10, 1'b1, OpMrs, 2'd0, 2'd0, 1'b0);
        expect_cmd("mrs", 4'd9);
        issue(2'b10, 1'b1, OpZqc, 2'd0, 2'd0, 1'b0);
        expect_cmd("zqc", 4'd10);
        issue(2'b10, 1'b1, OpPre, 2'd3, 2'd3, 1'b0);
        expect_cmd("pre_closed", 4'd6);
        check("pre_closed_open", bank_open, 32'h10000);

        // PREA on rank 1: first blocked by bank 16, then by young bank 25
        issue(2'b01, 1'b1, OpPre | A10, 2'd0, 2'd0, 1'b0);
        expect_err("prea_a", 3'd6);
        check("prea_a_open", bank_open, 32'h10000);
        issue(2'b01, 1'b0, 17'h00777, 2'd2, 2'd1, 1'b0);
        expect_cmd("act_b25", 4'd1);
        check("act_b25_open", bank_open, 32'h02010000);
        issue(2'b01, 1'b1, OpPre | A10, 2'd0, 2'd0, 1'b0);
        expect_err("prea_b", 3'd6);
        check("prea_b_open", bank_open, 32'h02010000);
        issue(2'b01, 1'b1, OpWr | 17'h3FF, 2'd2, 2'd1, 1'b0);
        expect_err("wr_early", 3'd5);
        des(1);
        issue(2'b01, 1'b1, OpWr | 17'h3FF, 2'd2, 2'd1, 1'b0);
        expect_cmd("wr_ok", 4'd4);
        check("wr_ok_col", 32'(cmd_col), 32'h3FF);
        check("wr_ok_row", 32'(cmd_row), 32'h0777);
        check("wr_ok_bg", 32'(cmd_bg), 32'd2);
        check("wr_ok_ba", 32'(cmd_ba), 32'd1);
        des(5);
        issue(2'b01, 1'b1, OpPre | A10, 2'd0, 2'd0, 1'b0);
        expect_cmd("prea_ok", 4'd7);
        check("prea_ok_open", bank_open, 32'h0);

`ifdef DIMM_CA_PARITY_EN
        issue(2'b10, 1'b0, 17'h00042, 2'd0, 2'd3, 1'b1);
        expect_err("par", 3'd1);
        check("par_alert", 32'(alert_n), 32'd0);
        check("par_open", bank_open, 32'h0);
        des(1);
        check("par_alert_rel", 32'(alert_n), 32'd1);
`else
        issue(2'b10, 1'b1, OpMrs, 2'd0, 2'd0, 1'b1);
        expect_cmd("par_ignored", 4'd9);
        check("par_alert", 32'(alert_n), 32'd1);
        des(1);
`endif

        // Three banks open, then reset with a command presented
        issue(2'b10, 1'b0, 17'h00010, 2'd0, 2'd0, 1'b0);
        issue(2'b10, 1'b0, 17'h00011, 2'd0, 2'd1, 1'b0);
        issue(2'b01, 1'b0, 17'h00012, 2'd3, 2'd3, 1'b0);
        expect_cmd("act3", 4'd1);
        check("act3_open", bank_open, 32'h80000003);
        reset_n = 1'b0;
        issue(2'b10, 1'b0, 17'h00013, 2'd2, 2'd2, 1'b0);
        expect_none("rst_mid");
        check("rst_mid_open", bank_open, 32'h0);
        check("rst_mid_row", 32'(cmd_row), 32'h0);
        reset_n = 1'b1;
        des(1);
        expect_none("rst_after");
        check("rst_after_open", bank_open, 32'h0);
        issue(2'b10, 1'b0, 17'h00014, 2'd0, 2'd0, 1'b0);
        expect_cmd("act_post_rst", 4'd1);
        check("act_post_rst_open", bank_open, 32'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
